vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. Generates hsync/vsync/de for any timing set, with configurable sync polarity and a configurable pixel-request lead so sources with 1..N cycles of read latency can feed it. All outputs are registered. Adds frame-boundary start/stop control, frame/line start strobes and a sticky pixel-underflow flag. Sits between the frame-buffer read path (ov5640 capture -> SDRAM/FIFO) and the VGA pins.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_cnt.sv | 40 ++++
 rtl/vga_timing_gen.sv | 219 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding and default 640x480@60 timing for the VGA timing generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vga_state_e;

  // Default 640x480@60 timing (25.175 MHz pixel clock), with 8-pixel borders.
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 40;
  localparam int DEF_H_LEFT   = 8;
  localparam int DEF_H_VALID  = 640;
  localparam int DEF_H_RIGHT  = 8;
  localparam int DEF_H_FRONT  = 8;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 25;
  localparam int DEF_V_TOP    = 8;
  localparam int DEF_V_VALID  = 480;
  localparam int DEF_V_BOTTOM = 8;
  localparam int DEF_V_FRONT  = 2;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis counter, 0..MAX with wrap, hold-at-zero clear and terminal count.
// Latency: count updates one clock after inc; tc is combinational from the count register.
// Backpressure: none; inc simply holds the count when low.
// Ports: clk/rst_n clock and async reset; clr forces zero; inc advances; cnt value; tc at MAX.
module vga_axis_cnt #(
  parameter int W   = 10,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(MAX));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/de generator with a pixel-request lead for latent sources.
// Latency: every output is registered and describes the counter position of the previous clock.
// Backpressure: none; a source that misses its slot gives rgb=0 and sets the sticky underflow.
// Ports: vga_clk/sys_rst_n clock and async reset; en run request (stop lands on a frame end);
//   pix_data/pix_valid source pixel; underflow_clr; pix_req/pix_x/pix_y pixel request;
//   hsync/vsync/de/rgb video out; frame_start/line_start strobes; underflow sticky; busy.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   H_LEFT   = DEF_H_LEFT,
  parameter int   H_VALID  = DEF_H_VALID,
  parameter int   H_RIGHT  = DEF_H_RIGHT,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter int   V_TOP    = DEF_V_TOP,
  parameter int   V_VALID  = DEF_V_VALID,
  parameter int   V_BOTTOM = DEF_V_BOTTOM,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   REQ_LEAD = 1,
  parameter int   CNT_W    = 10,
  parameter int   DATA_W   = 16
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              underflow_clr,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start,
  output logic              underflow,
  output logic              busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK + H_LEFT;
  localparam int VA      = V_SYNC + V_BACK + V_TOP;

  // Window compares run one bit wider so hp+REQ_LEAD near the line end cannot wrap
  // back into the active window.
  localparam int XW = CNT_W + 1;
  localparam logic [XW-1:0] H_SYNC_X = XW'(H_SYNC);
  localparam logic [XW-1:0] H_ACT_LO = XW'(HA);
  localparam logic [XW-1:0] H_ACT_HI = XW'(HA + H_VALID);
  localparam logic [XW-1:0] V_SYNC_X = XW'(V_SYNC);
  localparam logic [XW-1:0] V_ACT_LO = XW'(VA);
  localparam logic [XW-1:0] V_ACT_HI = XW'(VA + V_VALID);
  localparam logic [XW-1:0] LEAD_X   = XW'(REQ_LEAD);

  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (REQ_LEAD < 1 || REQ_LEAD > HA) begin : g_bad_req_lead
    $error("vga_timing_gen: REQ_LEAD must be in 1..H_SYNC+H_BACK+H_LEFT");
  end

  vga_state_e        state_q;
  vga_state_e        state_d;
  logic [CNT_W-1:0]  hp;
  logic [CNT_W-1:0]  vp;
  logic              h_tc;
  logic              v_tc;
  logic              running;
  logic [XW-1:0]     hx;
  logic [XW-1:0]     vx;
  logic [XW-1:0]     rx;
  logic              h_act;
  logic              v_act;
  logic              r_act;

  logic              pix_req_q,     pix_req_d;
  logic [CNT_W-1:0]  pix_x_q,       pix_x_d;
  logic [CNT_W-1:0]  pix_y_q,       pix_y_d;
  logic              hsync_q,       hsync_d;
  logic              vsync_q,       vsync_d;
  logic              de_q,          de_d;
  logic [DATA_W-1:0] rgb_q,         rgb_d;
  logic              frame_start_q, frame_start_d;
  logic              line_start_q,  line_start_d;
  logic              underflow_q,   underflow_d;
  logic              busy_q,        busy_d;

  assign running = (state_q != IDLE);

  // Counters are held at zero while idle, so the first RUN clock is position (0,0).
  vga_axis_cnt #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .clr   (!running),
    .inc   (1'b1),
    .cnt   (hp),
    .tc    (h_tc)
  );

  vga_axis_cnt #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .clr   (!running),
    .inc   (h_tc),
    .cnt   (vp),
    .tc    (v_tc)
  );

  // A stop request only lands on the last clock of a frame; re-raising en while
  // draining cancels the stop without disturbing the counters.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = STOPPING;
      STOPPING: begin
        if (en) begin
          state_d = RUN;
        end else if (h_tc && v_tc) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  assign hx    = {1'b0, hp};
  assign vx    = {1'b0, vp};
  assign rx    = hx + LEAD_X;
  assign h_act = (hx >= H_ACT_LO) && (hx < H_ACT_HI);
  assign v_act = (vx >= V_ACT_LO) && (vx < V_ACT_HI);
  assign r_act = (rx >= H_ACT_LO) && (rx < H_ACT_HI);

  always_comb begin
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    pix_req_d     = 1'b0;
    pix_x_d       = '1;
    pix_y_d       = '1;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (running) begin
      hsync_d       = (hx < H_SYNC_X) ? HS_POL : ~HS_POL;
      vsync_d       = (vx < V_SYNC_X) ? VS_POL : ~VS_POL;
      de_d          = h_act && v_act;
      frame_start_d = (hp == '0) && (vp == '0);
      line_start_d  = (hp == '0);
      if (r_act && v_act) begin
        pix_req_d = 1'b1;
        pix_x_d   = hp + CNT_W'(REQ_LEAD) - CNT_W'(HA);
        pix_y_d   = vp - CNT_W'(VA);
      end
    end

    rgb_d = (de_d && pix_valid) ? pix_data : '0;

    // A fresh miss outranks a clear on the same clock so no underflow is lost.
    underflow_d = underflow_q;
    if (underflow_clr) underflow_d = 1'b0;
    if (de_d && !pix_valid) underflow_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      pix_req_q     <= 1'b0;
      pix_x_q       <= '1;
      pix_y_q       <= '1;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      underflow_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_req_q     <= pix_req_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      underflow_q   <= underflow_d;
      busy_q        <= busy_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign underflow   = underflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-timing bench, two instances (REQ_LEAD=2 and REQ_LEAD=1) on shared controls.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; the bench acts as an ideal source that answers each request on time.
module tb_vga_timing_gen;

  localparam int HT  = 10;  // H_TOTAL
  localparam int FT  = 60;  // clocks per frame
  localparam int HA  = 4;
  localparam int VA  = 2;
  localparam int HV  = 4;
  localparam int VV  = 3;
  localparam int HSY = 2;
  localparam int VSY = 1;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [15:0] pix_data1 = '0;
  logic [15:0] pix_data2 = '0;

  logic        pix_req1, pix_req2;
  logic [9:0]  pix_x1, pix_x2, pix_y1, pix_y2;
  logic        hsync1, hsync2, vsync1, vsync2, de1, de2;
  logic [15:0] rgb1, rgb2;
  logic        frame_start1, frame_start2, line_start1, line_start2;
  logic        underflow1, underflow2, busy1, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_LEFT(1), .H_VALID(4), .H_RIGHT(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_TOP(0), .V_VALID(3), .V_BOTTOM(0), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .REQ_LEAD(2), .CNT_W(10), .DATA_W(16)
  ) dut2 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_data(pix_data2),
    .pix_valid(pix_valid), .underflow_clr(underflow_clr), .pix_req(pix_req2),
    .pix_x(pix_x2), .pix_y(pix_y2), .hsync(hsync2), .vsync(vsync2), .de(de2),
    .rgb(rgb2), .frame_start(frame_start2), .line_start(line_start2),
    .underflow(underflow2), .busy(busy2)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_LEFT(1), .H_VALID(4), .H_RIGHT(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_TOP(0), .V_VALID(3), .V_BOTTOM(0), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .REQ_LEAD(1), .CNT_W(10), .DATA_W(16)
  ) dut1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_data(pix_data1),
    .pix_valid(pix_valid), .underflow_clr(underflow_clr), .pix_req(pix_req1),
    .pix_x(pix_x1), .pix_y(pix_y1), .hsync(hsync1), .vsync(vsync1), .de(de1),
    .rgb(rgb1), .frame_start(frame_start1), .line_start(line_start1),
    .underflow(underflow1), .busy(busy1)
  );

  // ---------------- reference model: frame position as a single index ----------------
  typedef struct packed {
    logic       req;
    logic [9:0] px;
    logic [9:0] py;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       ls;
  } view_t;

  int    m_mode = 0;   // 0 idle, 1 running, 2 finishing the frame before idling
  int    m_n    = 0;   // clock index within the frame, 0..FT-1
  bit    m_uf   = 1'b0;
  view_t last2  = '0;

  function automatic view_t frame_view(bit act, int n, int lead);
    view_t o;
    int    h, v, hr;
    bit    vact;
    o    = '0;
    o.px = '1;
    o.py = '1;
    o.hs = 1'b1;
    h    = n % HT;
    v    = n / HT;
    hr   = h + lead;
    if (act) begin
      vact = (v >= VA) && (v < VA + VV);
      o.hs = !(h < HSY);
      o.vs = (v < VSY);
      o.de = vact && (h >= HA) && (h < HA + HV);
      o.fs = (n == 0);
      o.ls = (h == 0);
      if (vact && (hr >= HA) && (hr < HA + HV)) begin
        o.req = 1'b1;
        o.px  = 10'(hr - HA);
        o.py  = 10'(v - VA);
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: wait budget expired", nm, cyc);
  endtask

  // One clock: predict from model + applied inputs, let the edge happen, compare, advance model.
  task automatic tick();
    view_t       o1, o2;
    bit          act, e_uf, e_busy;
    logic [15:0] e_rgb1, e_rgb2;
    int          nm, nn;
    act    = (m_mode != 0);
    o2     = frame_view(act, m_n, 2);
    o1     = frame_view(act, m_n, 1);
    e_rgb2 = (o2.de && pix_valid) ? pix_data2 : 16'd0;
    e_rgb1 = (o1.de && pix_valid) ? pix_data1 : 16'd0;
    e_uf   = (o2.de && !pix_valid) || (m_uf && !underflow_clr);
    nm = m_mode;
    nn = act ? (m_n + 1) % FT : 0;
    case (m_mode)
      0: if (en) nm = 1;
      1: if (!en) nm = 2;
      default: begin
        if (en) nm = 1;
        else if (m_n == FT - 1) nm = 0;
      end
    endcase
    e_busy = (nm != 0);

    @(posedge vga_clk);
    #1;
    cyc++;
    chk("req2", pix_req2, o2.req);   chk("req1", pix_req1, o1.req);
    chk("px2", pix_x2, o2.px);       chk("px1", pix_x1, o1.px);
    chk("py2", pix_y2, o2.py);       chk("py1", pix_y1, o1.py);
    chk("hsync2", hsync2, o2.hs);    chk("hsync1", hsync1, o1.hs);
    chk("vsync2", vsync2, o2.vs);    chk("vsync1", vsync1, o1.vs);
    chk("de2", de2, o2.de);          chk("de1", de1, o1.de);
    chk("rgb2", rgb2, e_rgb2);       chk("rgb1", rgb1, e_rgb1);
    chk("fs2", frame_start2, o2.fs); chk("fs1", frame_start1, o1.fs);
    chk("ls2", line_start2, o2.ls);  chk("ls1", line_start1, o1.ls);
    chk("uf2", underflow2, e_uf);    chk("uf1", underflow1, e_uf);
    chk("busy2", busy2, e_busy);     chk("busy1", busy1, e_busy);

    m_mode = nm;
    m_n    = nn;
    m_uf   = e_uf;

    // Ideal sources: lead 2 answers one clock after its request, lead 1 in the same clock.
    pix_data2 = last2.req ? {6'd0, last2.px} : 16'($urandom);
    pix_data1 = o1.req ? {6'd0, o1.px} : 16'($urandom);
    last2     = o2;
  endtask

  // ---------------- directed first-frame vectors ----------------
  typedef struct {
    int          k;      // sample index after en is raised
    logic        valid;  // pix_valid applied for this clock
    logic        hs, vs, de;
    logic [15:0] rgb;
    logic        req2;
    logic [9:0]  px2;
    logic        req1;
    logic [9:0]  px1;
    logic        fs, ls, busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int    ti, t0, t1, nfs;
    bit    found;
    view_t pv;

    //           k  vl hs vs de rgb  rq2 px2    rq1 px1    fs ls by
    tbl[0]  = '{ 1, 1, 1, 0, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[1]  = '{ 2, 1, 0, 1, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 1, 1, 1};
    tbl[2]  = '{ 3, 1, 0, 1, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[3]  = '{ 4, 1, 1, 1, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[4]  = '{12, 1, 0, 0, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 1, 1};
    tbl[5]  = '{24, 1, 1, 0, 0, 16'd0, 1, 10'd0,   0, 10'h3FF, 0, 0, 1};
    tbl[6]  = '{25, 1, 1, 0, 0, 16'd0, 1, 10'd1,   1, 10'd0,   0, 0, 1};
    tbl[7]  = '{26, 1, 1, 0, 1, 16'd0, 1, 10'd2,   1, 10'd1,   0, 0, 1};
    tbl[8]  = '{27, 1, 1, 0, 1, 16'd1, 1, 10'd3,   1, 10'd2,   0, 0, 1};
    tbl[9]  = '{28, 1, 1, 0, 1, 16'd2, 0, 10'h3FF, 1, 10'd3,   0, 0, 1};
    tbl[10] = '{29, 1, 1, 0, 1, 16'd3, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[11] = '{30, 1, 1, 0, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[12] = '{36, 1, 1, 0, 1, 16'd0, 1, 10'd2,   1, 10'd1,   0, 0, 1};
    tbl[13] = '{56, 1, 1, 0, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 0, 0, 1};
    tbl[14] = '{62, 1, 0, 1, 0, 16'd0, 0, 10'h3FF, 0, 10'h3FF, 1, 1, 1};

    // Reset held: registered outputs at their inactive values.
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_hsync", hsync2, 1'b1);
    chk("rst_vsync", vsync2, 1'b0);
    chk("rst_de", de2, 1'b0);
    chk("rst_busy", busy2, 1'b0);
    chk("rst_px", pix_x2, 10'h3FF);
    chk("rst_py", pix_y1, 10'h3FF);
    chk("rst_uf", underflow1, 1'b0);
    sys_rst_n = 1'b1;

    // Idle with en low for 50 clocks.
    repeat (50) tick();

    // First frame with an always-valid source.
    en = 1'b1;
    ti = 0;
    for (int k = 1; k <= 62; k++) begin
      pix_valid = 1'b1;
      if (ti < 15 && tbl[ti].k == k) pix_valid = tbl[ti].valid;
      tick();
      if (ti < 15 && tbl[ti].k == k) begin
        chk("v_hsync", hsync2, tbl[ti].hs);
        chk("v_vsync", vsync2, tbl[ti].vs);
        chk("v_de", de2, tbl[ti].de);
        chk("v_rgb2", rgb2, tbl[ti].rgb);
        chk("v_rgb1", rgb1, tbl[ti].rgb);
        chk("v_req2", pix_req2, tbl[ti].req2);
        chk("v_px2", pix_x2, tbl[ti].px2);
        chk("v_req1", pix_req1, tbl[ti].req1);
        chk("v_px1", pix_x1, tbl[ti].px1);
        chk("v_fs", frame_start2, tbl[ti].fs);
        chk("v_ls", line_start2, tbl[ti].ls);
        chk("v_busy", busy2, tbl[ti].busy);
        ti++;
      end
    end

    // Stop requested on line 3: frame must complete, then idle with no further frames.
    for (int i = 0; i < 100 && m_n != 30; i++) tick();
    if (m_n != 30) expire("reach_line3");
    en = 1'b0;
    for (int i = 0; i < 100 && busy2 === 1'b1; i++) tick();
    chk("stop_busy_fall", busy2, 1'b0);
    nfs = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (frame_start2 === 1'b1) nfs++;
    end
    chk("stop_no_frame_start", nfs, 0);

    // Stop cancelled mid-drain: frame cadence must be unbroken.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (frame_start2 === 1'b1) found = 1'b1;
    end
    if (!found) expire("restart_fs");
    t0 = cyc;
    for (int i = 0; i < 100 && m_n != 20; i++) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (frame_start2 === 1'b1) found = 1'b1;
    end
    if (!found) expire("cancel_fs");
    t1 = cyc;
    chk("frame_spacing", t1 - t0, FT);

    // Underflow: one missing active pixel, sticky, cleared, and set-beats-clear.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      pv = frame_view(1'b1, m_n, 2);
      if (pv.de) found = 1'b1;
      else tick();
    end
    if (!found) expire("find_de_1");
    pix_valid = 1'b0;
    tick();
    chk("uf_rgb_zero", rgb2, 16'd0);
    chk("uf_set", underflow2, 1'b1);
    pix_valid = 1'b1;
    repeat (5) tick();
    chk("uf_sticky", underflow2, 1'b1);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("uf_cleared", underflow2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      pv = frame_view(1'b1, m_n, 2);
      if (pv.de) found = 1'b1;
      else tick();
    end
    if (!found) expire("find_de_2");
    pix_valid = 1'b0;
    underflow_clr = 1'b1;
    tick();
    chk("uf_set_beats_clr", underflow2, 1'b1);
    pix_valid = 1'b1;
    underflow_clr = 1'b0;

    // Randomised run/stop, source misses and clears against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) en = !en;
      pix_valid     = ($urandom_range(0, 19) != 0);
      underflow_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
